aux_register_bank: RTL and testbench
====================================

// Module: aux_register_bank
// PURPOSE
//  Responder for the frame generator's auxiliary-data read port: returns aux_data for aux_raddress with zero latency.
//  CPU writes go to a shadow bank through a valid/ready handshake.
//  The shadow bank is committed to the display-visible front bank once per frame, at the v_sync falling edge, so no frame tears.
//  Sits between the CPU bus and frame_generator in the VGA pipeline, clocked by the pixel clock.
// PARAMETERS
//  DATA_WIDTH         16  width of one aux word
//  AUX_ADDRESS_WIDTH  5   aux address width
//  AUX_DEPTH          32  implemented words, 1..2**AUX_ADDRESS_WIDTH
// PORTS
//  clock_in            in   1                  pixel clock, all logic on rising edge
//  reset_n_in          in   1                  asynchronous active-low reset
//  cpu_wr_valid_in     in   1                  CPU write request
//  cpu_wr_ready_out    out  1                  bank can accept a write this cycle
//  cpu_wr_address_in   in   AUX_ADDRESS_WIDTH  shadow write address
//  cpu_wr_data_in      in   DATA_WIDTH         shadow write data
//  v_sync_in           in   1                  VGA vertical sync, active-low pulse
//  aux_raddress_in     in   AUX_ADDRESS_WIDTH  read address from frame_generator
//  aux_data_out        out  DATA_WIDTH         front-bank word, combinational
//  commit_pending_out  out  1                  shadow holds writes not yet committed
//  frame_count_out     out  16                 v_sync falling edges since reset, wraps
// BEHAVIOUR
//  Reset (async, reset_n_in=0):
//   - front[] = shadow[] = 0; dirty = 0; state = IDLE; frame_count = 0
//   - v_sync history reg = 1, so release never produces a false edge
//   - outputs during reset: ready = 1, aux_data_out = 0, commit_pending_out = 0
//  Write handshake: write occurs when valid && ready on a rising edge.
//   - shadow[addr] <= data; dirty <= 1
//   - address >= AUX_DEPTH: write is accepted and discarded; dirty is unchanged
//   - cpu_wr_ready_out = (state == IDLE)
//  Read: aux_data_out = front[aux_raddress_in] in the same cycle; address >= AUX_DEPTH -> 0
//  Edge detect: fall = vs_q && !v_sync_in, where vs_q is v_sync_in registered once.
//   - v_sync_in is synchronous to clock_in, so no synchronizer is used
//  FSM (2 states):
//   - IDLE  : fall && (dirty || write this cycle) -> COMMIT; else stay IDLE
//   - COMMIT: one cycle, ready = 0; at its end front[] <= shadow[] (all words), dirty <= 0, -> IDLE
//  Timing:
//   - edge cycle N: IDLE, write at N is accepted and included in the commit
//   - cycle N+1: COMMIT; the new front values are visible at N+2
//   - frame_count increments at the end of cycle N on every fall, whether or not a commit occurs
//  Simultaneous events: a write stalled during COMMIT (valid held, ready = 0) completes at N+2 and sets dirty for the next frame.
//  Reset mid-COMMIT: the copy is abandoned; all banks are cleared.
//  commit_pending_out = dirty (registered).
// STRUCTURE
//  Package vga_pkg: DATA_WIDTH, AUX_ADDRESS_WIDTH defaults, typedef enum logic {AUX_IDLE, AUX_COMMIT} aux_state_t.
//  Sub-module sync_fall_detect: vs_q register (reset to 1) plus fall pulse; reusable for h_sync.
//  Both banks are flip-flop arrays (AUX_DEPTH x DATA_WIDTH), which the single-cycle full copy requires.
// TESTING
//  1. Reset, then write addr 2 = 16'h07FF with no v_sync edge -> aux_data_out(addr 2) stays 0; commit_pending_out = 1.
//  2. Continue from 1, drive v_sync 1->0 -> ready = 0 for exactly one cycle; two cycles after the edge aux_data_out(addr 2) = 16'h07FF; pending = 0; frame_count = 1.
//  3. Write addr k = k for k = 0..31, then one edge -> after commit every address reads k; addr 0 reads 16'h0000.
//  4. Hold valid with addr 5 = 16'hABCD on the edge cycle, then addr 6 = 16'h1234 during COMMIT -> addr 5 is committed in this frame; addr 6 is accepted two cycles after the edge and committed at the next edge.
//  5. AUX_DEPTH = 20, write addr 25 -> accepted, pending stays 0, read addr 25 = 0; v_sync edge with no writes -> no COMMIT cycle, frame_count still increments.
//  6. Assert reset_n_in low during the COMMIT cycle -> all outputs take reset values immediately; no false edge is detected after release while v_sync_in = 1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and default widths for the VGA pipeline blocks.
package vga_pkg;

  localparam int DEFAULT_DATA_WIDTH        = 16;
  localparam int DEFAULT_AUX_ADDRESS_WIDTH = 5;

  typedef enum logic {
    AUX_IDLE   = 1'b0,
    AUX_COMMIT = 1'b1
  } aux_state_t;

endpackage

// File: rtl/sync_fall_detect.sv
// Falling-edge detector for a sync strobe that is already in the pixel-clock
// domain. The history register resets high, so a line held high through
// reset release never produces a spurious edge. Usable for v_sync or h_sync.
module sync_fall_detect (
  input  logic clock_in,
  input  logic reset_n_in,
  input  logic sync_in,
  output logic fall_out
);

  logic r_sync_q;

  // One-cycle history of the sync line.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) r_sync_q <= 1'b1;
    else             r_sync_q <= sync_in;
  end

  assign fall_out = r_sync_q & ~sync_in;

endmodule

// File: rtl/aux_register_bank.sv
// Double-buffered auxiliary register bank for the frame generator.
// CPU writes land in a shadow bank; the whole shadow bank is copied to the
// display-visible front bank in one cycle after a v_sync falling edge, so a
// frame never shows a partial update.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   AUX_IDLE   | accepting CPU writes; waiting for a v_sync fall with dirty data
//   AUX_COMMIT | one cycle: CPU stalled, front bank loads shadow at cycle end
module aux_register_bank
  import vga_pkg::*;
#(
  parameter int DATA_WIDTH        = DEFAULT_DATA_WIDTH,
  parameter int AUX_ADDRESS_WIDTH = DEFAULT_AUX_ADDRESS_WIDTH,
  parameter int AUX_DEPTH         = 32
) (
  input  logic                         clock_in,
  input  logic                         reset_n_in,
  input  logic                         cpu_wr_valid_in,
  output logic                         cpu_wr_ready_out,
  input  logic [AUX_ADDRESS_WIDTH-1:0] cpu_wr_address_in,
  input  logic [DATA_WIDTH-1:0]        cpu_wr_data_in,
  input  logic                         v_sync_in,
  input  logic [AUX_ADDRESS_WIDTH-1:0] aux_raddress_in,
  output logic [DATA_WIDTH-1:0]        aux_data_out,
  output logic                         commit_pending_out,
  output logic [15:0]                  frame_count_out
);

  // Depth widened by one bit so a full 2**AUX_ADDRESS_WIDTH depth is representable.
  localparam logic [AUX_ADDRESS_WIDTH:0] LP_DEPTH = AUX_DEPTH[AUX_ADDRESS_WIDTH:0];

  aux_state_t r_state;
  aux_state_t w_state_next;

  logic [DATA_WIDTH-1:0] r_front  [AUX_DEPTH];
  logic [DATA_WIDTH-1:0] r_shadow [AUX_DEPTH];
  logic                  r_dirty;
  logic [15:0]           r_frame_count;

  logic w_fall;
  logic w_wr_fire;
  logic w_wr_in_range;
  logic w_rd_in_range;

  sync_fall_detect u_vsync_fall (
    .clock_in   (clock_in),
    .reset_n_in (reset_n_in),
    .sync_in    (v_sync_in),
    .fall_out   (w_fall)
  );

  assign cpu_wr_ready_out = (r_state == AUX_IDLE);
  assign w_wr_fire        = cpu_wr_valid_in & cpu_wr_ready_out;
  assign w_wr_in_range    = ({1'b0, cpu_wr_address_in} < LP_DEPTH);
  assign w_rd_in_range    = ({1'b0, aux_raddress_in} < LP_DEPTH);

  // State register.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) r_state <= AUX_IDLE;
    else             r_state <= w_state_next;
  end

  // Next state: commit only when there is something new to show; a write in
  // the edge cycle itself counts, since it lands in the shadow before the copy.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      AUX_IDLE:   if (w_fall && (r_dirty || w_wr_fire)) w_state_next = AUX_COMMIT;
      AUX_COMMIT: w_state_next = AUX_IDLE;
      default:    w_state_next = AUX_IDLE;
    endcase
  end

  // Shadow bank: accepted CPU writes; out-of-range addresses are dropped.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < AUX_DEPTH; i++) r_shadow[i] <= '0;
    end else if (w_wr_fire && w_wr_in_range) begin
      r_shadow[cpu_wr_address_in] <= cpu_wr_data_in;
    end
  end

  // Front bank: full single-cycle copy at the end of the commit cycle.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < AUX_DEPTH; i++) r_front[i] <= '0;
    end else if (r_state == AUX_COMMIT) begin
      for (int i = 0; i < AUX_DEPTH; i++) r_front[i] <= r_shadow[i];
    end
  end

  // Dirty flag: no write can fire during commit, so clearing there loses nothing.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in)                      r_dirty <= 1'b0;
    else if (r_state == AUX_COMMIT)       r_dirty <= 1'b0;
    else if (w_wr_fire && w_wr_in_range)  r_dirty <= 1'b1;
  end

  // Frame counter: every v_sync fall, committed or not.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in)  r_frame_count <= '0;
    else if (w_fall)  r_frame_count <= r_frame_count + 16'd1;
  end

  assign aux_data_out       = w_rd_in_range ? r_front[aux_raddress_in] : '0;
  assign commit_pending_out = r_dirty;
  assign frame_count_out    = r_frame_count;

endmodule

// File: tb/tb_aux_register_bank.sv
// Bench for aux_register_bank: a 32-deep and a 20-deep instance share all
// stimulus and are both compared every cycle against a frame-level model.
module tb_aux_register_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        vsync;
  logic [4:0]  raddr;

  logic        ready32, pend32, ready20, pend20;
  logic [15:0] data32, fc32, data20, fc20;

  int n_checks = 0;
  int n_err    = 0;

  // Model: per-instance banks, dirty flag and "next cycle is the copy" flag.
  logic [15:0] m_front  [2][32];
  logic [15:0] m_shadow [2][32];
  bit          m_dirty  [2];
  bit          m_cm     [2];
  logic [15:0] m_fc;
  bit          m_vs;

  typedef struct {
    bit          valid;
    logic [4:0]  addr;
    logic [15:0] data;
    bit          vs;
    logic [4:0]  ra;
    bit          e_ready;
    logic [15:0] e_data;
    bit          e_pend;
    logic [15:0] e_fc;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  aux_register_bank #(.DATA_WIDTH(16), .AUX_ADDRESS_WIDTH(5), .AUX_DEPTH(32)) u_dut32 (
    .clock_in           (clk),
    .reset_n_in         (rst_n),
    .cpu_wr_valid_in    (wr_valid),
    .cpu_wr_ready_out   (ready32),
    .cpu_wr_address_in  (wr_addr),
    .cpu_wr_data_in     (wr_data),
    .v_sync_in          (vsync),
    .aux_raddress_in    (raddr),
    .aux_data_out       (data32),
    .commit_pending_out (pend32),
    .frame_count_out    (fc32)
  );

  aux_register_bank #(.DATA_WIDTH(16), .AUX_ADDRESS_WIDTH(5), .AUX_DEPTH(20)) u_dut20 (
    .clock_in           (clk),
    .reset_n_in         (rst_n),
    .cpu_wr_valid_in    (wr_valid),
    .cpu_wr_ready_out   (ready20),
    .cpu_wr_address_in  (wr_addr),
    .cpu_wr_data_in     (wr_data),
    .v_sync_in          (vsync),
    .aux_raddress_in    (raddr),
    .aux_data_out       (data20),
    .commit_pending_out (pend20),
    .frame_count_out    (fc20)
  );

  function automatic int dep(int k);
    return (k == 0) ? 32 : 20;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) begin
        m_front[k][i]  = '0;
        m_shadow[k][i] = '0;
      end
      m_dirty[k] = 0;
      m_cm[k]    = 0;
    end
    m_fc = '0;
    m_vs = 1;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_step();
    bit fall;
    bit fire;
    bit old_dirty;
    fall = m_vs && !vsync;
    for (int k = 0; k < 2; k++) begin
      if (m_cm[k]) begin
        for (int i = 0; i < 32; i++) m_front[k][i] = m_shadow[k][i];
        m_dirty[k] = 0;
        m_cm[k]    = 0;
      end else begin
        fire      = wr_valid;
        old_dirty = m_dirty[k];
        if (fire && int'(wr_addr) < dep(k)) begin
          m_shadow[k][wr_addr] = wr_data;
          m_dirty[k]           = 1;
        end
        if (fall && (old_dirty || fire)) m_cm[k] = 1;
      end
    end
    if (fall) m_fc = m_fc + 16'd1;
    m_vs = vsync;
  endtask

  function automatic logic [15:0] m_read(int k, logic [4:0] a);
    return (int'(a) < dep(k)) ? m_front[k][a] : 16'h0000;
  endfunction

  task automatic model_check();
    chk("m32_ready", 32'(ready32), 32'(!m_cm[0]));
    chk("m32_data",  32'(data32),  32'(m_read(0, raddr)));
    chk("m32_pend",  32'(pend32),  32'(m_dirty[0]));
    chk("m32_fc",    32'(fc32),    32'(m_fc));
    chk("m20_ready", 32'(ready20), 32'(!m_cm[1]));
    chk("m20_data",  32'(data20),  32'(m_read(1, raddr)));
    chk("m20_pend",  32'(pend20),  32'(m_dirty[1]));
    chk("m20_fc",    32'(fc20),    32'(m_fc));
  endtask

  // Called just after inputs settle in the low clock phase.
  task automatic tick();
    model_check();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(bit v, logic [4:0] a, logic [15:0] d, bit vs, logic [4:0] ra);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    vsync    = vs;
    raddr    = ra;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_valid = 0; wr_addr = '0; wr_data = '0; vsync = 1'b1; raddr = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Tests 1-2: single write, then one v_sync fall and the commit that follows.
    tbl[0] = '{1'b0, 5'd0, 16'h0000, 1'b1, 5'd2, 1'b1, 16'h0000, 1'b0, 16'd0};
    tbl[1] = '{1'b1, 5'd2, 16'h07FF, 1'b1, 5'd2, 1'b1, 16'h0000, 1'b0, 16'd0};
    tbl[2] = '{1'b0, 5'd0, 16'h0000, 1'b1, 5'd2, 1'b1, 16'h0000, 1'b1, 16'd0};
    tbl[3] = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd2, 1'b1, 16'h0000, 1'b1, 16'd0};
    tbl[4] = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd2, 1'b0, 16'h0000, 1'b1, 16'd1};
    tbl[5] = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd2, 1'b1, 16'h07FF, 1'b0, 16'd1};
    tbl[6] = '{1'b0, 5'd0, 16'h0000, 1'b1, 5'd2, 1'b1, 16'h07FF, 1'b0, 16'd1};
    tbl[7] = '{1'b0, 5'd0, 16'h0000, 1'b1, 5'd3, 1'b1, 16'h0000, 1'b0, 16'd1};
    for (int r = 0; r < 8; r++) begin
      drive(tbl[r].valid, tbl[r].addr, tbl[r].data, tbl[r].vs, tbl[r].ra);
      chk($sformatf("tbl%0d_ready", r), 32'(ready32), 32'(tbl[r].e_ready));
      chk($sformatf("tbl%0d_data", r),  32'(data32),  32'(tbl[r].e_data));
      chk($sformatf("tbl%0d_pend", r),  32'(pend32),  32'(tbl[r].e_pend));
      chk($sformatf("tbl%0d_fc", r),    32'(fc32),    32'(tbl[r].e_fc));
      tick();
    end

    // Test 3: fill every address with its own index, then one frame edge.
    for (int k = 0; k < 32; k++) begin
      drive(1'b1, 5'(k), 16'(k), 1'b1, 5'd0);
      tick();
    end
    drive(1'b0, 5'd0, 16'h0, 1'b0, 5'd0); tick();
    drive(1'b0, 5'd0, 16'h0, 1'b0, 5'd0); tick();
    for (int k = 0; k < 32; k++) begin
      drive(1'b0, 5'd0, 16'h0, 1'b1, 5'(k));
      chk($sformatf("t3_rd32_%0d", k), 32'(data32), 32'(k));
      chk($sformatf("t3_rd20_%0d", k), 32'(data20), (k < 20) ? 32'(k) : 32'd0);
      tick();
    end

    // Test 4: write held on the edge cycle, second write stalled by the commit.
    drive(1'b1, 5'd5, 16'hABCD, 1'b0, 5'd5);
    chk("t4_edge_ready", 32'(ready32), 32'd1);
    chk("t4_edge_data5", 32'(data32), 32'h5);
    tick();
    drive(1'b1, 5'd6, 16'h1234, 1'b0, 5'd5);
    chk("t4_commit_ready", 32'(ready32), 32'd0);
    tick();
    drive(1'b1, 5'd6, 16'h1234, 1'b0, 5'd5);
    chk("t4_n2_ready", 32'(ready32), 32'd1);
    chk("t4_n2_data5", 32'(data32), 32'hABCD);
    tick();
    drive(1'b0, 5'd0, 16'h0, 1'b1, 5'd6);
    chk("t4_pend_after", 32'(pend32), 32'd1);
    chk("t4_data6_old", 32'(data32), 32'h6);
    tick();
    drive(1'b0, 5'd0, 16'h0, 1'b0, 5'd6); tick();
    drive(1'b0, 5'd0, 16'h0, 1'b0, 5'd6); tick();
    drive(1'b0, 5'd0, 16'h0, 1'b1, 5'd6);
    chk("t4_data6_new", 32'(data32), 32'h1234);
    chk("t4_pend_clear", 32'(pend32), 32'd0);
    tick();

    // Test 5: out-of-range write on the 20-deep bank, then an edge with nothing to commit.
    drive(1'b1, 5'd25, 16'hBEEF, 1'b1, 5'd25);
    chk("t5_ready20", 32'(ready20), 32'd1);
    tick();
    drive(1'b0, 5'd0, 16'h0, 1'b1, 5'd25);
    chk("t5_pend20", 32'(pend20), 32'd0);
    chk("t5_rd25_20", 32'(data20), 32'd0);
    tick();
    drive(1'b0, 5'd0, 16'h0, 1'b0, 5'd25); tick();
    drive(1'b0, 5'd0, 16'h0, 1'b0, 5'd25);
    chk("t5_no_commit20", 32'(ready20), 32'd1);
    chk("t5_fc20", 32'(fc20), 32'd5);
    tick();
    drive(1'b0, 5'd0, 16'h0, 1'b1, 5'd25); tick();

    // Test 6: reset asserted in the middle of a commit cycle.
    drive(1'b1, 5'd3, 16'h5555, 1'b1, 5'd3); tick();
    drive(1'b0, 5'd0, 16'h0, 1'b0, 5'd3); tick();
    chk("t6_in_commit", 32'(ready32), 32'd0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_ready", 32'(ready32), 32'd1);
    chk("t6_rst_data", 32'(data32), 32'd0);
    chk("t6_rst_pend", 32'(pend32), 32'd0);
    chk("t6_rst_fc", 32'(fc32), 32'd0);
    vsync = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 16'h0, 1'b1, 5'd3);
      tick();
    end
    drive(1'b0, 5'd0, 16'h0, 1'b1, 5'd3);
    chk("t6_no_false_edge", 32'(fc32), 32'd0);
    chk("t6_front_cleared", 32'(data32), 32'd0);
    tick();

    // Randomized traffic with occasional v_sync toggles.
    for (int n = 0; n < 800; n++) begin
      logic vs_next;
      vs_next = ($urandom_range(0, 5) == 0) ? ~vsync : vsync;
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 16'($urandom),
            vs_next, 5'($urandom_range(0, 31)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
